fp_align_seq: RTL and testbench
===============================

Name: fp_align_seq

Overview:
- Multi-cycle sequencer for a right-shift-with-sticky alignment datapath used in FP add/sub exponent alignment.
- Accepts one mantissa and shift count through a valid/ready handshake.
- Runs the shift as a series of bounded per-cycle steps, ORing shifted-out bits into a sticky flag.
- Returns the aligned mantissa, sticky and a passthrough tag through a second valid/ready handshake.
- Lets large shift counts reuse a narrow, cheap shifter stage.

Parameters:
- A_WIDTH, 23: mantissa width, min 1.
- SH_WIDTH, 8: shift-count width, min 1.
- STEP_WIDTH, 3: per-cycle shift field width. STEP_MAX = 2^STEP_WIDTH-1 (default 7), min STEP_WIDTH 1.
- TAG_WIDTH, 4: sideband tag width, min 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  sequencer can accept a request.
- in_a  input  A_WIDTH  mantissa to align.
- in_sh  input  SH_WIDTH  right-shift amount (unsigned).
- in_tag  input  TAG_WIDTH  sideband, returned unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_b  output  A_WIDTH  in_a >> in_sh (logical).
- out_stk  output  1  OR of all bits shifted out.
- out_tag  output  TAG_WIDTH  captured in_tag.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset: async on rst_n low.
  - State returns to IDLE.
  - out_valid=0, out_b=0, out_stk=0, out_tag=0, busy=0, internal remaining count=0.
  - in_ready=1 while in reset, because it is decoded from IDLE.
  - Reset mid-operation discards the job; no output is produced for it.
- FSM states: IDLE, SHIFT, DONE. in_ready = (state==IDLE). out_valid = (state==DONE). busy = !IDLE.
- Accept: in_valid && in_ready at a rising edge captures in_a into a_reg, in_sh into rem, in_tag into tag_reg, and clears sticky.
  - Next state is DONE if in_sh==0, else SHIFT.
- SHIFT, each cycle:
  - step = min(rem, STEP_MAX).
  - a_reg <= a_reg >> step.
  - sticky <= sticky | (|(a_reg & ~(all_ones << step))).
  - rem <= rem - step.
  - Go to DONE when rem - step == 0, else stay in SHIFT.
- Width rules:
  - step is zero-extended to SH_WIDTH for the subtraction; rem never underflows.
  - A step >= A_WIDTH (possible when STEP_MAX >= A_WIDTH) yields a_reg=0 and sticky |= |a_reg.
- DONE: out_b=a_reg, out_stk=sticky, out_tag=tag_reg, all held stable while out_valid && !out_ready.
  - out_ready high returns the FSM to IDLE at that edge.
  - No same-cycle re-accept: in_ready is low in DONE, giving one bubble per job.
- Latency from the accepting edge to out_valid high: 1 + ceil(in_sh/STEP_MAX) cycles. in_sh=0 gives 1 cycle.
- in_valid while busy is ignored. Inputs are not sampled and no error is flagged.
- Inputs may change freely after the accepting edge.
- out_ready while !out_valid has no effect.

Optional Feature:
- Macro: FP_ALIGN_SEQ_FAST_SAT_EN.
- Defined: on accept with in_sh >= A_WIDTH, go to SHIFT for exactly one cycle, which sets a_reg=0, sticky=|in_a and rem=0, then DONE.
  - Latency is 2 cycles for any saturating shift.
  - in_sh=0 still takes the direct-to-DONE path.
- Undefined: saturating shifts iterate normally; with defaults in_sh=255 takes 37 SHIFT cycles.
- Results are bit-identical either way; only latency differs.

Test Plan (defaults, FAST_SAT off unless noted):
- Zero shift: in_a=0x400001, in_sh=0, tag=3 -> out_valid 1 cycle after accept; out_b=0x400001, out_stk=0, out_tag=3.
- Two-step shift: in_a=0x7FFFFF, in_sh=10 -> steps 7 then 3; out_valid 3 cycles after accept; out_b=0x001FFF, out_stk=1.
- Sticky boundary:
  - in_a=0x000400, in_sh=10 -> out_b=0x000001, out_stk=0.
  - in_a=0x000401, in_sh=10 -> out_b=0x000001, out_stk=1.
- Saturation: in_a=0x000001, in_sh=255 -> out_b=0, out_stk=1.
  - Without the macro, out_valid at accept+38.
  - With FP_ALIGN_SEQ_FAST_SAT_EN, out_valid at accept+2.
- Backpressure: complete in_sh=7 job, hold out_ready=0 for 5 cycles while driving in_valid=1 with new data.
  - Outputs stay stable, in_ready=0 and the new request is not captured.
  - out_ready=1 gives IDLE next cycle, and the new request is accepted on the following edge.
- Reset mid-op: assert rst_n=0 during SHIFT of in_sh=20.
  - All outputs go to 0 immediately and in_ready=1.
  - After release, no stale result appears and a new job completes correctly.

Source files
------------

// File: rtl/fp_align_seq_if.sv
// Request/response bundle for the alignment sequencer.
// slave  : sequencer side (takes requests, produces results)
// master : requester/consumer side
interface fp_align_seq_if #(
  parameter int A_WIDTH   = 23,
  parameter int SH_WIDTH  = 8,
  parameter int TAG_WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [A_WIDTH-1:0]   in_a;
  logic [SH_WIDTH-1:0]  in_sh;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [A_WIDTH-1:0]   out_b;
  logic                 out_stk;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 busy;

  modport slave (
    input  in_valid, in_a, in_sh, in_tag, out_ready,
    output in_ready, out_valid, out_b, out_stk, out_tag, busy
  );

  modport master (
    output in_valid, in_a, in_sh, in_tag, out_ready,
    input  in_ready, out_valid, out_b, out_stk, out_tag, busy
  );
endinterface

// File: rtl/fp_align_seq.sv
// Multi-cycle right-shift-with-sticky sequencer for FP exponent alignment.
// A large shift is broken into steps of at most STEP_MAX bits per cycle so
// only a narrow shifter is needed; bits shifted out are ORed into sticky.
// Optional macro FP_ALIGN_SEQ_FAST_SAT_EN: shifts >= A_WIDTH finish in a
// single SHIFT cycle (same result, shorter latency).
//
// state   | meaning
// S_IDLE  | waiting for a request, in_ready high
// S_SHIFT | applying one bounded shift step per cycle
// S_DONE  | result held on outputs until out_ready
module fp_align_seq #(
  parameter int A_WIDTH    = 23,
  parameter int SH_WIDTH   = 8,
  parameter int STEP_WIDTH = 3,
  parameter int TAG_WIDTH  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_align_seq_if.slave  bus
);

  localparam int STEP_MAX = (1 << STEP_WIDTH) - 1;
  // Common width so the step clamp works whichever of rem/step is wider.
  localparam int CW = (SH_WIDTH > STEP_WIDTH) ? SH_WIDTH : STEP_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [A_WIDTH-1:0]   r_a;
  logic [SH_WIDTH-1:0]  r_rem;
  logic [TAG_WIDTH-1:0] r_tag;
  logic                 r_stk;

  logic [CW-1:0]        w_rem_ext;
  logic [CW-1:0]        w_step;
  logic [SH_WIDTH-1:0]  w_step_sh;
  logic [SH_WIDTH-1:0]  w_rem_nxt;
  logic [A_WIDTH-1:0]   w_lost_mask;
  logic                 w_accept;
  logic                 w_last;

  assign w_rem_ext   = CW'(r_rem);
  assign w_step      = (w_rem_ext < CW'(STEP_MAX)) ? w_rem_ext : CW'(STEP_MAX);
  // step <= rem, so truncating back to SH_WIDTH is lossless and rem cannot underflow.
  assign w_step_sh   = SH_WIDTH'(w_step);
  assign w_rem_nxt   = r_rem - w_step_sh;
  // Shift amounts >= A_WIDTH give an all-ones mask, so every bit counts as lost.
  assign w_lost_mask = ~({A_WIDTH{1'b1}} << w_step);
  assign w_accept    = bus.in_valid && (r_state == S_IDLE);

`ifdef FP_ALIGN_SEQ_FAST_SAT_EN
  localparam logic [31:0] A_W32 = A_WIDTH;
  logic r_sat;
  logic w_in_sat;
  assign w_in_sat = (32'(bus.in_sh) >= A_W32);
  assign w_last   = r_sat || (w_rem_nxt == '0);
`else
  assign w_last   = (w_rem_nxt == '0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (bus.in_sh == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, one bounded shift step per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_rem <= '0;
      r_tag <= '0;
      r_stk <= 1'b0;
`ifdef FP_ALIGN_SEQ_FAST_SAT_EN
      r_sat <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a   <= bus.in_a;
      r_rem <= bus.in_sh;
      r_tag <= bus.in_tag;
      r_stk <= 1'b0;
`ifdef FP_ALIGN_SEQ_FAST_SAT_EN
      r_sat <= w_in_sat;
`endif
    end else if (r_state == S_SHIFT) begin
`ifdef FP_ALIGN_SEQ_FAST_SAT_EN
      if (r_sat) begin
        r_a   <= '0;
        r_stk <= r_stk | (|r_a);
        r_rem <= '0;
        r_sat <= 1'b0;
      end else begin
        r_a   <= r_a >> w_step;
        r_stk <= r_stk | (|(r_a & w_lost_mask));
        r_rem <= w_rem_nxt;
      end
`else
      r_a   <= r_a >> w_step;
      r_stk <= r_stk | (|(r_a & w_lost_mask));
      r_rem <= w_rem_nxt;
`endif
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_b     = r_a;
  assign bus.out_stk   = r_stk;
  assign bus.out_tag   = r_tag;

endmodule

// File: tb/tb_fp_align_seq.sv
// Directed bench for fp_align_seq with hand-computed results.
// Saturating-shift latency expectation follows FP_ALIGN_SEQ_FAST_SAT_EN.
module tb_fp_align_seq;

  localparam int A_WIDTH   = 23;
  localparam int SH_WIDTH  = 8;
  localparam int TAG_WIDTH = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  fp_align_seq_if #(.A_WIDTH(A_WIDTH), .SH_WIDTH(SH_WIDTH), .TAG_WIDTH(TAG_WIDTH)) bus ();

  fp_align_seq #(
    .A_WIDTH(A_WIDTH), .SH_WIDTH(SH_WIDTH), .STEP_WIDTH(3), .TAG_WIDTH(TAG_WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input int sh);
    if (sh == 0) return 1;
`ifdef FP_ALIGN_SEQ_FAST_SAT_EN
    if (sh >= A_WIDTH) return 2;
`endif
    return 1 + (sh + 6) / 7;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, measure latency to out_valid, check result, drain.
  task automatic run_job(input string name, input logic [22:0] a, input int sh,
                         input logic [3:0] tag, input logic [22:0] exp_b, input logic exp_stk);
    int cnt;
    cnt = 0;
    while (!bus.in_ready && cnt < 100) begin tick(); cnt++; end
    chk({name, "_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_sh    = SH_WIDTH'(sh);
    bus.in_tag   = tag;
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = '1;
    bus.in_sh    = '1;
    bus.in_tag   = '1;
    cnt = 1;
    while (!bus.out_valid && cnt < 200) begin tick(); cnt++; end
    chk({name, "_lat"}, 32'(cnt), 32'(exp_lat(sh)));
    chk({name, "_b"},   32'(bus.out_b),   32'(exp_b));
    chk({name, "_stk"}, 32'(bus.out_stk), 32'(exp_stk));
    chk({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({name, "_idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
  endtask

  initial begin
    int cnt;
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_sh     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready),  32'd1);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_b",     32'(bus.out_b),     32'd0);
    chk("rst_stk_tag", {27'd0, bus.out_stk, bus.out_tag}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    run_job("zero",   23'h400001, 0,   4'd3, 23'h400001, 1'b0);
    run_job("two",    23'h7FFFFF, 10,  4'd5, 23'h001FFF, 1'b1);
    run_job("stk0",   23'h000400, 10,  4'd1, 23'h000001, 1'b0);
    run_job("stk1",   23'h000401, 10,  4'd2, 23'h000001, 1'b1);
    run_job("one7",   23'h123456, 7,   4'd7, 23'h002468, 1'b1);
    run_job("two14",  23'h123456, 14,  4'd8, 23'h000048, 1'b1);
    run_job("full23", 23'h7FFFFF, 23,  4'd4, 23'h000000, 1'b1);
    run_job("sat255", 23'h000001, 255, 4'hA, 23'h000000, 1'b1);
    run_job("sat0",   23'h000000, 255, 4'hB, 23'h000000, 1'b0);

    // Backpressure: result held while new requests are refused.
    bus.in_valid = 1'b1;
    bus.in_a     = 23'h000080;
    bus.in_sh    = 8'd7;
    bus.in_tag   = 4'hC;
    tick();
    bus.in_a   = 23'h7FFFFF;
    bus.in_sh  = 8'd0;
    bus.in_tag = 4'h9;
    tick();
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {bus.out_tag, bus.out_stk, bus.out_b}, {4'hC, 1'b0, 23'h000001});
      chk("bp_flags", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'b011);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_new_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_new_res", {bus.out_tag, bus.out_stk, bus.out_b}, {4'h9, 1'b0, 23'h7FFFFF});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset in the middle of a job.
    bus.in_valid = 1'b1;
    bus.in_a     = 23'h7FFFFF;
    bus.in_sh    = 8'd20;
    bus.in_tag   = 4'h6;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
    chk("mid_rst_data", {bus.out_tag, bus.out_stk, bus.out_b}, 28'd0);
    tick(); tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid) cnt++;
    end
    chk("mid_no_stale", 32'(cnt), 32'd0);
    run_job("post", 23'h7FFFFF, 20, 4'h6, 23'h000007, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
